// File: rtl/hazard_ctrl_seq.sv
// hazard_ctrl_seq: hazard controller for the 5-stage MIPS pipeline.
// Produces D/E forwarding selects, the load-use / fetch / memory / divider
// stall vectors and flushE. It also tracks the divider's busy time internally
// and runs the exception-redirect sequencer.
//
// Ports
//   clk, rst                  clock (rising edge), synchronous active-high reset
//   stallreq_if/_mem          fetch not ready / data access pending in M
//   rsD, rtD                  D-stage source registers
//   rsE, rtE, rdE             E-stage source registers / CP0 register index
//   div_startE                divide issued in E (level, held while stalled)
//   writereg{E,M,W}           destination register per stage
//   regwrite{E,M,W}           GPR write enable per stage
//   memtoregE                 E-stage instruction is a load
//   hilo_write{M,W}           HI/LO write in M/W
//   cp0_write{M,W}            CP0 write in M/W
//   excepttype, cp0_epc       exception code taken in M (nonzero), EPC value
//   fwd{a,b}D                 00 regfile, 10 from E, 01 from M
//   fwd{a,b}E                 00 regfile, 10 from M, 01 from W
//   fwdHiLoE, fwdCP0E         00 none, 10 from M, 01 from W
//   stallF..stallW            per-stage hold enables
//   flushE                    bubble into E
//   flush_all                 flush every stage
//   div_done                  one-cycle pulse when the quotient is valid
//   pc_redirect, newpc        registered redirect request and target PC
module hazard_ctrl_seq #(
  parameter int unsigned RW        = 5,
  parameter int unsigned DW        = 32,
  parameter int unsigned DIV_LAT   = 32,
  parameter int unsigned FLUSH_CYC = 1,
  parameter logic [DW-1:0] EXC_VEC   = 32'hBFC00380,
  parameter logic [DW-1:0] ERET_CODE = 32'h0000000E
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stallreq_if,
  input  logic          stallreq_mem,
  input  logic [RW-1:0] rsD,
  input  logic [RW-1:0] rtD,
  input  logic [RW-1:0] rsE,
  input  logic [RW-1:0] rtE,
  input  logic [RW-1:0] rdE,
  input  logic          div_startE,
  input  logic [RW-1:0] writeregE,
  input  logic [RW-1:0] writeregM,
  input  logic [RW-1:0] writeregW,
  input  logic          regwriteE,
  input  logic          regwriteM,
  input  logic          regwriteW,
  input  logic          memtoregE,
  input  logic          hilo_writeM,
  input  logic          hilo_writeW,
  input  logic          cp0_writeM,
  input  logic          cp0_writeW,
  input  logic [DW-1:0] excepttype,
  input  logic [DW-1:0] cp0_epc,
  output logic [1:0]    fwdaD,
  output logic [1:0]    fwdbD,
  output logic [1:0]    fwdaE,
  output logic [1:0]    fwdbE,
  output logic [1:0]    fwdHiLoE,
  output logic [1:0]    fwdCP0E,
  output logic          stallF,
  output logic          stallD,
  output logic          stallE,
  output logic          stallM,
  output logic          stallW,
  output logic          flushE,
  output logic          flush_all,
  output logic          div_done,
  output logic          pc_redirect,
  output logic [DW-1:0] newpc
);

  localparam int unsigned CW  = $clog2(DIV_LAT + 1);
  localparam int unsigned FCW = $clog2(FLUSH_CYC + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FLUSH = 2'd1,
    S_REDIR = 2'd2
  } state_t;

  state_t         r_state, w_state_nxt;
  logic [FCW-1:0] r_fcnt;
  logic [DW-1:0]  r_newpc;
  logic           r_busy;
  logic [CW-1:0]  r_cnt;

  logic w_exc_det;
  logic w_flush_all;
  logic w_redirect;
  logic w_kill;
  logic w_lwstall;
  logic w_stall_div;

  // ---------------------------------------------------------------- forwarding
  always_comb begin
    fwdaD = 2'b00;
    fwdbD = 2'b00;
    fwdaE = 2'b00;
    fwdbE = 2'b00;
    fwdHiLoE = 2'b00;
    fwdCP0E  = 2'b00;

    if (rsD != '0 && regwriteE && rsD == writeregE)      fwdaD = 2'b10;
    else if (rsD != '0 && regwriteM && rsD == writeregM) fwdaD = 2'b01;
    if (rtD != '0 && regwriteE && rtD == writeregE)      fwdbD = 2'b10;
    else if (rtD != '0 && regwriteM && rtD == writeregM) fwdbD = 2'b01;

    if (rsE != '0 && regwriteM && rsE == writeregM)      fwdaE = 2'b10;
    else if (rsE != '0 && regwriteW && rsE == writeregW) fwdaE = 2'b01;
    if (rtE != '0 && regwriteM && rtE == writeregM)      fwdbE = 2'b10;
    else if (rtE != '0 && regwriteW && rtE == writeregW) fwdbE = 2'b01;

    if (hilo_writeM)      fwdHiLoE = 2'b10;
    else if (hilo_writeW) fwdHiLoE = 2'b01;

    if (cp0_writeM && rdE == writeregM)      fwdCP0E = 2'b10;
    else if (cp0_writeW && rdE == writeregW) fwdCP0E = 2'b01;
  end

  // ------------------------------------------------------- exception sequencer
  assign w_exc_det = (r_state == S_IDLE) && (excepttype != '0);

  always_comb begin
    w_state_nxt = r_state;
    w_flush_all = 1'b0;
    w_redirect  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_exc_det) begin
          w_flush_all = 1'b1;
          w_state_nxt = S_FLUSH;
        end
      end
      S_FLUSH: begin
        w_flush_all = 1'b1;
        if (r_fcnt == '0) w_state_nxt = S_REDIR;
      end
      S_REDIR: begin
        w_redirect = 1'b1;
        if (!stallreq_if) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_fcnt  <= '0;
      r_newpc <= '0;
    end else begin
      r_state <= w_state_nxt;
      // newpc is only captured on detection, so it stays stable until IDLE returns
      if (w_exc_det) begin
        r_newpc <= (excepttype == ERET_CODE) ? cp0_epc : EXC_VEC;
        r_fcnt  <= FCW'(FLUSH_CYC - 1);
      end else if (r_state == S_FLUSH && r_fcnt != '0) begin
        r_fcnt <= r_fcnt - FCW'(1);
      end
    end
  end

  assign w_kill = w_flush_all | w_redirect;

  // ------------------------------------------------------------------ divider
  // A start that arrives while the pipeline is being flushed belongs to a
  // squashed instruction, so it does not launch a divide.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
    end else if (w_exc_det) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
    end else if (r_busy) begin
      if (r_cnt == '0) r_busy <= 1'b0;
      else             r_cnt  <= r_cnt - CW'(1);
    end else if (div_startE && !w_kill) begin
      r_busy <= 1'b1;
      r_cnt  <= CW'(DIV_LAT - 1);
    end
  end

  assign w_stall_div = (div_startE & ~r_busy) | (r_busy & (r_cnt != '0));
  assign div_done    = r_busy & (r_cnt == '0) & ~w_exc_det;

  // ------------------------------------------------------------------- stalls
  assign w_lwstall = memtoregE & regwriteE & (writeregE != '0) &
                     ((writeregE == rsD) | (writeregE == rtD));

  assign stallF = ~w_kill & (w_stall_div | w_lwstall | stallreq_if | stallreq_mem);
  assign stallD = ~w_kill & (w_stall_div | w_lwstall | stallreq_mem);
  assign stallE = ~w_kill & (w_stall_div | stallreq_mem);
  assign stallM = ~w_kill & stallreq_mem;
  assign stallW = 1'b0;
  assign flushE = ~w_kill & w_lwstall & ~(w_stall_div | stallreq_mem);

  assign flush_all   = w_flush_all;
  assign pc_redirect = w_redirect;
  assign newpc       = r_newpc;

endmodule
